// File: rtl/spi_master_nch.sv
// SPI master with N slave selects, runtime CPOL/CPHA/bit order, programmable
// half-period divisor and an optional select hold between frames.
module spi_master_nch #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DVSR_W = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [DVSR_W-1:0]                          dvsr,
  input  logic [DATA_W-1:0]                          tx_data,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
  input  logic                                       start,
  input  logic                                       cpol,
  input  logic                                       cpha,
  input  logic                                       lsb_first,
  input  logic                                       hold_ss,
  input  logic                                       ss_release,
  input  logic                                       miso,
  output logic [DATA_W-1:0]                          rx_data,
  output logic                                       ready,
  output logic                                       done_tick,
  output logic                                       spi_clk,
  output logic                                       mosi,
  output logic [NUM_SS-1:0]                          ss_n,
  output logic [2:0]                                 state_dbg
);

  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BC_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    P1    = 3'd2,
    P2    = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [DVSR_W-1:0] cnt, cnt_n, dvsr_q, dvsr_n;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic              cpol_q, cpol_n, cpha_q, cpha_n, lsb_q, lsb_n, hold_q, hold_n;
  logic [SS_W-1:0]   sel_q, sel_n, held_idx, held_idx_n;
  logic              held, held_n;
  logic              last;
  logic              done_n, spi_clk_n, mosi_n;
  logic [NUM_SS-1:0] ss_n_n;

  // Active-low one-cold mask; an out-of-range index selects nothing.
  function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_W-1:0] idx);
    sel_mask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (idx == SS_W'(i)) sel_mask[i] = 1'b0;
    end
  endfunction

  assign ready     = (state == IDLE);
  assign state_dbg = state;
  assign last      = (cnt == dvsr_q);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dvsr_n     = dvsr_q;
    bit_cnt_n  = bit_cnt;
    tx_sh_n    = tx_sh;
    rx_sh_n    = rx_sh;
    cpol_n     = cpol_q;
    cpha_n     = cpha_q;
    lsb_n      = lsb_q;
    hold_n     = hold_q;
    sel_n      = sel_q;
    held_n     = held;
    held_idx_n = held_idx;

    if (state != IDLE) cnt_n = last ? '0 : cnt + DVSR_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          dvsr_n    = dvsr;
          tx_sh_n   = tx_data;
          cpol_n    = cpol;
          cpha_n    = cpha;
          lsb_n     = lsb_first;
          hold_n    = hold_ss;
          sel_n     = ss_sel;
          cnt_n     = '0;
          bit_cnt_n = '0;
          // The held line is taken over by the frame's own select from here on.
          held_n    = 1'b0;
          state_n   = (held && (ss_sel == held_idx)) ? P1 : LEAD;
        end else if (ss_release) begin
          held_n = 1'b0;
        end
      end
      LEAD: begin
        if (last) state_n = P1;
      end
      P1: begin
        if (last) begin
          state_n = P2;
          rx_sh_n = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        end
      end
      P2: begin
        if (last) begin
          if (bit_cnt == BC_W'(DATA_W - 1)) begin
            state_n = TRAIL;
          end else begin
            state_n   = P1;
            bit_cnt_n = bit_cnt + BC_W'(1);
            tx_sh_n   = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
          end
        end
      end
      TRAIL: begin
        if (last) begin
          state_n    = IDLE;
          held_n     = hold_q;
          held_idx_n = sel_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output pins are computed from next-cycle values so they are plain flops.
  always_comb begin
    done_n = (state_n == TRAIL) && (cnt_n == dvsr_n);
    case (state_n)
      P1:      spi_clk_n = cpol_n ^ cpha_n;
      P2:      spi_clk_n = ~(cpol_n ^ cpha_n);
      IDLE:    spi_clk_n = cpol;
      default: spi_clk_n = cpol_n;
    endcase
    mosi_n = 1'b0;
    if (state_n != IDLE) mosi_n = lsb_n ? tx_sh_n[0] : tx_sh_n[DATA_W-1];
    ss_n_n = '1;
    if (state_n != IDLE) ss_n_n = sel_mask(sel_n);
    else if (held_n)     ss_n_n = sel_mask(held_idx_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvsr_q    <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      hold_q    <= 1'b0;
      sel_q     <= '0;
      held      <= 1'b0;
      held_idx  <= '0;
      rx_data   <= '0;
      done_tick <= 1'b0;
      spi_clk   <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dvsr_q    <= dvsr_n;
      bit_cnt   <= bit_cnt_n;
      tx_sh     <= tx_sh_n;
      rx_sh     <= rx_sh_n;
      cpol_q    <= cpol_n;
      cpha_q    <= cpha_n;
      lsb_q     <= lsb_n;
      hold_q    <= hold_n;
      sel_q     <= sel_n;
      held      <= held_n;
      held_idx  <= held_idx_n;
      // rx_data becomes valid together with done_tick.
      if (done_n) rx_data <= rx_sh_n;
      done_tick <= done_n;
      spi_clk   <= spi_clk_n;
      mosi      <= mosi_n;
      ss_n      <= ss_n_n;
    end
  end

endmodule

// File: tb/tb_spi_master_nch.sv
// Bench for spi_master_nch: directed and randomized frames checked against
// frame-level rules (length, bit order, select pattern, received word).
module tb_spi_master_nch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dvsr;
  logic [7:0]  tx_data;
  logic [1:0]  ss_sel;
  logic        start, cpol, cpha, lsb_first, hold_ss, ss_release;
  logic        miso;
  logic [7:0]  rx_data;
  logic        ready, done_tick, spi_clk, mosi;
  logic [3:0]  ss_n;
  logic [2:0]  state_dbg;

  logic        miso_force, miso_val, miso_inv;
  assign miso = miso_force ? miso_val : (mosi ^ miso_inv);

  // Second instance with a non-power-of-two select count, for illegal selects.
  logic [2:0]  ss_sel_b;
  logic        start_b, miso_b;
  logic [7:0]  rx_data_b;
  logic        ready_b, done_tick_b, spi_clk_b, mosi_b;
  logic [4:0]  ss_n_b;
  logic [2:0]  state_dbg_b;
  assign miso_b = mosi_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  spi_master_nch #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .tx_data(tx_data), .ss_sel(ss_sel),
    .start(start), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .hold_ss(hold_ss), .ss_release(ss_release), .miso(miso), .rx_data(rx_data),
    .ready(ready), .done_tick(done_tick), .spi_clk(spi_clk), .mosi(mosi),
    .ss_n(ss_n), .state_dbg(state_dbg)
  );

  spi_master_nch #(.DATA_W(8), .NUM_SS(5), .DVSR_W(16)) dut_b (
    .clk(clk), .reset(reset), .dvsr(dvsr), .tx_data(tx_data), .ss_sel(ss_sel_b),
    .start(start_b), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .hold_ss(hold_ss), .ss_release(ss_release), .miso(miso_b), .rx_data(rx_data_b),
    .ready(ready_b), .done_tick(done_tick_b), .spi_clk(spi_clk_b), .mosi(mosi_b),
    .ss_n(ss_n_b), .state_dbg(state_dbg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame and monitors it; cyc counts cycles from the acceptance
  // edge to done_tick inclusive (-1 if the budget runs out).
  task automatic run_frame(input logic [7:0] tx, input int dv, input logic pol,
                           input logic pha, input logic lsb, input logic hold,
                           input logic [1:0] sel, input logic spam,
                           output int cyc, output int p2_cnt,
                           output logic [7:0] mosi_word, output int ss_bad,
                           output logic first_mosi);
    logic       prev;
    logic [3:0] exp_ss;
    int         n;
    tx_data = tx; dvsr = 16'(dv); cpol = pol; cpha = pha; lsb_first = lsb;
    hold_ss = hold; ss_sel = sel; start = 1'b1;
    cyc = -1; p2_cnt = 0; mosi_word = '0; ss_bad = 0; prev = pol;
    exp_ss = ~(4'b0001 << sel);
    tick();
    start = 1'b0;
    first_mosi = mosi;
    n = 1;
    while (n <= 4000) begin
      if (ss_n !== exp_ss) ss_bad++;
      if (spi_clk !== prev) begin
        if (spi_clk === ~(pol ^ pha)) begin
          mosi_word = lsb ? {mosi, mosi_word[7:1]} : {mosi_word[6:0], mosi};
          p2_cnt++;
        end
        prev = spi_clk;
      end
      if (spam) begin
        if (n < 10 && (n % 3) == 0) begin
          start = 1'b1; tx_data = ~tx; dvsr = 16'(dv + 3); ss_sel = sel + 2'd1;
        end else begin
          start = 1'b0;
        end
      end
      if (done_tick === 1'b1) begin
        cyc = n;
        break;
      end
      tick();
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (ss_n !== 4'hf) $display("FAIL reset_ss_n got %b want 1111", ss_n); else passes++;
    checks++; if (spi_clk !== 1'b0) $display("FAIL reset_spi_clk got %b want 0", spi_clk); else passes++;
    checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi); else passes++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else passes++;
    checks++; if (done_tick !== 1'b0) $display("FAIL reset_done got %b want 0", done_tick); else passes++;
    reset = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passes++;
  endtask

  task automatic test_mode0_loopback();
    int cyc, p2, bad; logic [7:0] mw; logic fm;
    miso_force = 1'b0; miso_inv = 1'b0;
    run_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, cyc, p2, mw, bad, fm);
    checks++; if (cyc !== 36) $display("FAIL m0_len got %0d want 36", cyc); else passes++;
    checks++; if (p2 !== 8) $display("FAIL m0_rising got %0d want 8", p2); else passes++;
    checks++; if (bad !== 0) $display("FAIL m0_ss_n got %0d bad cycles want 0 (pattern 1011)", bad); else passes++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL m0_rx got %h want a5", rx_data); else passes++;
    checks++; if (mw !== 8'hA5) $display("FAIL m0_mosi_order got %h want a5", mw); else passes++;
    tick();
    checks++; if (done_tick !== 1'b0) $display("FAIL m0_done_width got %b want 0", done_tick); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL m0_ready_after got %b want 1", ready); else passes++;
    checks++; if (ss_n !== 4'hf) $display("FAIL m0_ss_idle got %b want 1111", ss_n); else passes++;
    checks++; if (mosi !== 1'b0) $display("FAIL m0_mosi_idle got %b want 0", mosi); else passes++;
  endtask

  task automatic test_mode3_lsb();
    int cyc, p2, bad; logic [7:0] mw; logic fm;
    cpol = 1'b1; cpha = 1'b1;
    tick(); tick();
    checks++; if (spi_clk !== 1'b1) $display("FAIL m3_idle_clk got %b want 1", spi_clk); else passes++;
    miso_force = 1'b1; miso_val = 1'b1;
    run_frame(8'h01, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, cyc, p2, mw, bad, fm);
    checks++; if (fm !== 1'b1) $display("FAIL m3_first_mosi got %b want 1", fm); else passes++;
    checks++; if (cyc !== 18) $display("FAIL m3_len got %0d want 18", cyc); else passes++;
    checks++; if (rx_data !== 8'hFF) $display("FAIL m3_rx got %h want ff", rx_data); else passes++;
    checks++; if (mw !== 8'h01) $display("FAIL m3_mosi_order got %h want 01", mw); else passes++;
    tick();
    checks++; if (spi_clk !== 1'b1) $display("FAIL m3_clk_after got %b want 1", spi_clk); else passes++;
    miso_force = 1'b0;
  endtask

  task automatic test_random();
    int cyc, p2, bad, dv; logic [7:0] tx, mw, exp_rx; logic fm, pol, pha, lsb;
    logic [1:0] sel;
    for (int i = 0; i < 8; i++) begin
      tx = 8'($urandom); dv = $urandom_range(0, 3);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      sel = 2'($urandom_range(0, 3)); miso_inv = 1'($urandom);
      exp_rx = miso_inv ? ~tx : tx;
      run_frame(tx, dv, pol, pha, lsb, 1'b0, sel, 1'b0, cyc, p2, mw, bad, fm);
      checks++; if (cyc !== 18 * (dv + 1)) $display("FAIL rnd%0d_len got %0d want %0d", i, cyc, 18 * (dv + 1)); else passes++;
      checks++; if (p2 !== 8) $display("FAIL rnd%0d_edges got %0d want 8", i, p2); else passes++;
      checks++; if (bad !== 0) $display("FAIL rnd%0d_ss_n got %0d bad cycles want 0", i, bad); else passes++;
      checks++; if (rx_data !== exp_rx) $display("FAIL rnd%0d_rx got %h want %h", i, rx_data, exp_rx); else passes++;
      checks++; if (mw !== tx) $display("FAIL rnd%0d_mosi got %h want %h", i, mw, tx); else passes++;
      tick();
    end
    miso_inv = 1'b0;
  endtask

  task automatic test_hold_ss();
    int cyc, p2, bad, gap_bad; logic [7:0] mw; logic fm;
    run_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, cyc, p2, mw, bad, fm);
    checks++; if (cyc !== 54) $display("FAIL hold1_len got %0d want 54", cyc); else passes++;
    gap_bad = 0;
    repeat (3) begin tick(); if (ss_n !== 4'b1101) gap_bad++; end
    checks++; if (gap_bad !== 0) $display("FAIL hold_gap_ss got %0d bad cycles want 0", gap_bad); else passes++;
    run_frame(8'hC3, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, cyc, p2, mw, bad, fm);
    checks++; if (cyc !== 51) $display("FAIL hold2_skip_lead got %0d want 51", cyc); else passes++;
    checks++; if (bad !== 0) $display("FAIL hold2_ss got %0d bad cycles want 0", bad); else passes++;
    checks++; if (rx_data !== 8'hC3) $display("FAIL hold2_rx got %h want c3", rx_data); else passes++;
    tick();
    checks++; if (ss_n !== 4'b1101) $display("FAIL hold2_idle_ss got %b want 1101", ss_n); else passes++;
    ss_release = 1'b1;
    tick();
    ss_release = 1'b0;
    checks++; if (ss_n !== 4'hf) $display("FAIL release_ss got %b want 1111", ss_n); else passes++;
    // Held select handed over to a different slave: new frame keeps LEAD.
    run_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, cyc, p2, mw, bad, fm);
    tick();
    run_frame(8'h66, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, cyc, p2, mw, bad, fm);
    checks++; if (cyc !== 18) $display("FAIL switch_len got %0d want 18", cyc); else passes++;
    checks++; if (bad !== 0) $display("FAIL switch_ss got %0d bad cycles want 0", bad); else passes++;
    tick();
    checks++; if (ss_n !== 4'hf) $display("FAIL switch_idle_ss got %b want 1111", ss_n); else passes++;
  endtask

  task automatic test_start_ignored();
    int cyc, p2, bad; logic [7:0] mw; logic fm;
    run_frame(8'h96, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, cyc, p2, mw, bad, fm);
    checks++; if (cyc !== 36) $display("FAIL busy_len got %0d want 36", cyc); else passes++;
    checks++; if (rx_data !== 8'h96) $display("FAIL busy_rx got %h want 96", rx_data); else passes++;
    checks++; if (mw !== 8'h96) $display("FAIL busy_mosi got %h want 96", mw); else passes++;
    checks++; if (bad !== 0) $display("FAIL busy_ss got %0d bad cycles want 0", bad); else passes++;
    tick();
  endtask

  task automatic test_reset_abort();
    int dones;
    tx_data = 8'hE7; dvsr = 16'd1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    hold_ss = 1'b0; ss_sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    reset = 1'b1;
    tick();
    checks++; if (ss_n !== 4'hf) $display("FAIL abort_ss got %b want 1111", ss_n); else passes++;
    checks++; if (spi_clk !== 1'b0) $display("FAIL abort_clk got %b want 0", spi_clk); else passes++;
    checks++; if (rx_data !== 8'h00) $display("FAIL abort_rx got %h want 00", rx_data); else passes++;
    reset = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) $display("FAIL abort_ready got %b want 1", ready); else passes++;
    dones = 0;
    repeat (40) begin if (done_tick === 1'b1) dones++; tick(); end
    checks++; if (dones !== 0) $display("FAIL abort_done got %0d pulses want 0", dones); else passes++;
  endtask

  task automatic test_invalid_sel();
    int cyc, bad;
    logic [7:0] tx;
    tx = 8'($urandom);
    tx_data = tx; dvsr = 16'd1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    hold_ss = 1'b0; ss_sel_b = 3'd5; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = -1; bad = 0;
    for (int n = 1; n <= 200; n++) begin
      if (ss_n_b !== 5'h1f) bad++;
      if (done_tick_b === 1'b1) begin cyc = n; break; end
      tick();
    end
    checks++; if (cyc !== 36) $display("FAIL badsel_len got %0d want 36", cyc); else passes++;
    checks++; if (bad !== 0) $display("FAIL badsel_ss got %0d bad cycles want 0", bad); else passes++;
    checks++; if (rx_data_b !== tx) $display("FAIL badsel_rx got %h want %h", rx_data_b, tx); else passes++;
    tick();
  endtask

  initial begin
    reset = 1'b1; dvsr = '0; tx_data = '0; ss_sel = '0; start = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; hold_ss = 1'b0; ss_release = 1'b0;
    miso_force = 1'b0; miso_val = 1'b0; miso_inv = 1'b0;
    ss_sel_b = '0; start_b = 1'b0;
    test_reset();
    test_mode0_loopback();
    test_mode3_lsb();
    test_random();
    test_hold_ss();
    test_start_ignored();
    test_reset_abort();
    test_invalid_sel();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
